// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: sequences one SoC test run (reset hold, settle, preload, exit-loop strap, run, result capture).
// Optional LOAD watchdog is compiled in when TB_RUN_CTRL_LOAD_TIMEOUT_EN is defined.
module tb_run_ctrl #(
  parameter int unsigned RESET_WAIT_CYCLES = 50,
  parameter int unsigned LOAD_TIMEOUT      = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        boot_sel_i,
  input  logic        exec_flash_i,
  input  logic [31:0] max_cycles_i,
  input  logic        load_done_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        soc_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        load_req_o,
  output logic        set_exit_loop_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] result_o,
  output logic [31:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    SETTLE,
    LOAD,
    EXIT_LOOP,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(RESET_WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        wait_last;
  logic        start_accept;
  logic        run_exit;
  logic        limit_hit;
  logic        boot_sel_q;
  logic        exec_flash_q;
  logic [31:0] max_cycles_q;

  assign wait_last    = (wait_cnt == WAIT_LAST);
  assign start_accept = start_i && ((state == IDLE) || (state == DONE));

`ifdef TB_RUN_CTRL_LOAD_TIMEOUT_EN
  localparam logic [31:0] LOAD_LAST = 32'(LOAD_TIMEOUT - 1);

  logic [31:0] load_cnt;
  logic        load_expired;

  // Counts cycles spent in LOAD; restarts at zero every time LOAD is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
    end else if (state == LOAD) begin
      load_cnt <= load_cnt + 32'd1;
    end else begin
      load_cnt <= '0;
    end
  end

  assign load_expired = (load_cnt == LOAD_LAST);
`else
  logic unused_load_timeout;
  assign unused_load_timeout = ^32'(LOAD_TIMEOUT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // In RUN the exit report is checked before the cycle limit so a simultaneous exit wins.
  always_comb begin
    state_next = state;
    run_exit   = 1'b0;
    limit_hit  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_i) state_next = RST_HOLD;
      end
      RST_HOLD: begin
        if (wait_last) state_next = SETTLE;
      end
      SETTLE: begin
        if (wait_last) state_next = boot_sel_q ? RUN : LOAD;
      end
      LOAD: begin
        if (load_done_i) begin
          state_next = EXIT_LOOP;
        end
`ifdef TB_RUN_CTRL_LOAD_TIMEOUT_EN
        else if (load_expired) begin
          state_next = DONE;
          limit_hit  = 1'b1;
        end
`endif
      end
      EXIT_LOOP: begin
        state_next = RUN;
      end
      RUN: begin
        if (exit_valid_i) begin
          state_next = DONE;
          run_exit   = 1'b1;
        end else if ((max_cycles_q != 32'd0) && (cycle_cnt_o >= max_cycles_q)) begin
          state_next = DONE;
          limit_hit  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shared wait counter for RST_HOLD and SETTLE; cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == RST_HOLD) || (state == SETTLE)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_sel_q   <= 1'b0;
      exec_flash_q <= 1'b0;
      max_cycles_q <= '0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      result_o     <= '0;
      cycle_cnt_o  <= '0;
    end else begin
      if (start_accept) begin
        boot_sel_q   <= boot_sel_i;
        exec_flash_q <= exec_flash_i;
        max_cycles_q <= max_cycles_i;
        done_o       <= 1'b0;
        pass_o       <= 1'b0;
        fail_o       <= 1'b0;
        timeout_o    <= 1'b0;
        result_o     <= '0;
        cycle_cnt_o  <= '0;
      end
      if ((state == RUN) && (state_next == RUN) && (cycle_cnt_o != 32'hFFFF_FFFF)) begin
        cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
      if (run_exit) begin
        done_o   <= 1'b1;
        result_o <= exit_value_i;
        pass_o   <= (exit_value_i == 32'd0);
        fail_o   <= (exit_value_i != 32'd0);
      end
      if (limit_hit) begin
        done_o    <= 1'b1;
        timeout_o <= 1'b1;
      end
    end
  end

  // rst_n gates the SoC reset directly so it drops the moment the controller is reset.
  assign soc_rst_no           = rst_n & (state != RST_HOLD);
  assign load_req_o           = (state == LOAD);
  assign set_exit_loop_o      = (state == EXIT_LOOP);
  assign boot_select_o        = boot_sel_q;
  assign execute_from_flash_o = boot_sel_q & exec_flash_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// tb_tb_run_ctrl: self-checking bench for tb_run_ctrl using a cycle-index timeline model.
// Define TB_RUN_CTRL_LOAD_TIMEOUT_EN for both files to exercise the LOAD watchdog.
module tb_tb_run_ctrl;
  localparam int RWC = 4;
  localparam int LT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic        boot_sel_i = 1'b0;
  logic        exec_flash_i = 1'b0;
  logic [31:0] max_cycles_i = '0;
  logic        load_done_i = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic        soc_rst_no;
  logic        boot_select_o;
  logic        execute_from_flash_o;
  logic        load_req_o;
  logic        set_exit_loop_o;
  logic        done_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic [31:0] result_o;
  logic [31:0] cycle_cnt_o;

  always #5 clk = ~clk;

  tb_run_ctrl #(.RESET_WAIT_CYCLES(RWC), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .boot_sel_i(boot_sel_i),
    .exec_flash_i(exec_flash_i), .max_cycles_i(max_cycles_i), .load_done_i(load_done_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i), .soc_rst_no(soc_rst_no),
    .boot_select_o(boot_select_o), .execute_from_flash_o(execute_from_flash_o),
    .load_req_o(load_req_o), .set_exit_loop_o(set_exit_loop_o), .done_o(done_o),
    .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o), .result_o(result_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Expected timeline, in cycle indices counted from the first cycle after the accepted start.
  int          exp_run_start, exp_done_c, exp_load_cycles, exp_load_rise, exp_pulse_c, exp_cnt;
  logic        exp_timeout, exp_pass, exp_fail;
  logic [31:0] exp_result;

  int          obs_soc_low, obs_soc_last_low, obs_load_cycles, obs_load_rise;
  int          obs_pulses, obs_pulse_c, obs_done_c;
  logic        obs_cleared, obs_boot0, obs_flash0, obs_boot_end, obs_load_at_done;
  logic        obs_timeout, obs_pass, obs_fail;
  logic [31:0] obs_result, obs_cnt;

  // d < 0 means the preload never completes; k is the RUN cycle index carrying exit_valid.
  task automatic model_run(input bit boot, input int d, input bit use_exit, input int k,
                           input logic [31:0] maxc, input logic [31:0] val);
    int end_idx;
    exp_timeout = 1'b0; exp_pass = 1'b0; exp_fail = 1'b0; exp_result = '0; exp_cnt = 0;
    exp_pulse_c = -1;
    exp_load_rise = boot ? -1 : 2 * RWC;
    if (!boot && d < 0) begin
      exp_run_start   = -1;
      exp_load_cycles = LT;
      exp_timeout     = 1'b1;
      exp_done_c      = 2 * RWC + LT;
    end else begin
      exp_load_cycles = boot ? 0 : d + 1;
      exp_pulse_c     = boot ? -1 : 2 * RWC + d + 1;
      exp_run_start   = 2 * RWC + (boot ? 0 : d + 2);
      if (maxc != 32'd0 && (!use_exit || maxc < 32'(k))) begin
        exp_timeout = 1'b1;
        end_idx     = int'(maxc);
      end else begin
        end_idx    = k;
        exp_result = val;
        exp_pass   = (val == 32'd0);
        exp_fail   = (val != 32'd0);
      end
      exp_cnt    = end_idx;
      exp_done_c = exp_run_start + end_idx + 1;
    end
  endtask

  // Starts a run and records what the outputs did each cycle until done_o or the budget runs out.
  task automatic drive_run(input bit boot, input bit flash, input logic [31:0] maxc, input int d,
                           input bit use_exit, input int k, input logic [31:0] val,
                           input bit noise, input int budget);
    @(negedge clk);
    start_i = 1'b1; boot_sel_i = boot; exec_flash_i = flash; max_cycles_i = maxc;
    load_done_i = 1'b0; exit_valid_i = 1'b0;
    obs_soc_low = 0; obs_soc_last_low = -1; obs_load_cycles = 0; obs_load_rise = -1;
    obs_pulses = 0; obs_pulse_c = -1; obs_done_c = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        obs_cleared = ({done_o, pass_o, fail_o, timeout_o} == 4'b0) && (result_o == 32'd0)
                      && (cycle_cnt_o == 32'd0);
        obs_boot0   = boot_select_o;
        obs_flash0  = execute_from_flash_o;
      end
      if (!soc_rst_no) begin obs_soc_low++; obs_soc_last_low = c; end
      if (load_req_o) begin
        if (obs_load_rise < 0) obs_load_rise = c;
        obs_load_cycles++;
      end
      if (set_exit_loop_o) begin obs_pulses++; obs_pulse_c = c; end
      if (done_o) begin
        obs_done_c = c; obs_timeout = timeout_o; obs_pass = pass_o; obs_fail = fail_o;
        obs_result = result_o; obs_cnt = cycle_cnt_o; obs_boot_end = boot_select_o;
        obs_load_at_done = load_req_o;
        break;
      end
      start_i      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      boot_sel_i   = 1'($urandom_range(0, 1));
      exec_flash_i = 1'($urandom_range(0, 1));
      max_cycles_i = $urandom;
      load_done_i  = (!boot && d >= 0 && c == 2 * RWC + d)
                     || (noise && c < 2 * RWC && $urandom_range(0, 1) == 1);
      exit_valid_i = (use_exit && exp_run_start >= 0 && c == exp_run_start + k)
                     || (noise && (exp_run_start < 0 || c < exp_run_start)
                         && $urandom_range(0, 1) == 1);
      exit_value_i = (exit_valid_i && c == exp_run_start + k) ? val : $urandom;
    end
    start_i = 1'b0; load_done_i = 1'b0; exit_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests_run++;
    if (soc_rst_no !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_soc_rst: got %b expected 0", soc_rst_no);
    end
    tests_run++;
    if ({done_o, pass_o, fail_o, timeout_o, load_req_o, set_exit_loop_o, boot_select_o,
         execute_from_flash_o, result_o, cycle_cnt_o} !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_outputs: got flags %b%b%b%b result %h cnt %h expected all 0",
                               done_o, pass_o, fail_o, timeout_o, result_o, cycle_cnt_o);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (soc_rst_no !== 1'b1 || load_req_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL idle_after_reset: got soc %b req %b done %b expected 1 0 0",
                               soc_rst_no, load_req_o, done_o);
    end
  endtask

  task automatic test_jtag_boot();
    model_run(1'b0, 3, 1'b1, 5, 32'd0, 32'd0);
    drive_run(1'b0, 1'b0, 32'd0, 3, 1'b1, 5, 32'd0, 1'b1, 500);
    tests_run++;
    if (obs_soc_low != RWC || obs_soc_last_low != RWC - 1) begin
      tests_failed++; $display("[TB] FAIL jtag_soc_low: got %0d cycles ending %0d expected %0d ending %0d",
                               obs_soc_low, obs_soc_last_low, RWC, RWC - 1);
    end
    tests_run++;
    if (obs_load_rise != exp_load_rise || obs_load_cycles != exp_load_cycles) begin
      tests_failed++; $display("[TB] FAIL jtag_load_req: got rise %0d len %0d expected rise %0d len %0d",
                               obs_load_rise, obs_load_cycles, exp_load_rise, exp_load_cycles);
    end
    tests_run++;
    if (obs_pulses != 1 || obs_pulse_c != exp_pulse_c) begin
      tests_failed++; $display("[TB] FAIL jtag_exit_loop: got %0d pulses at %0d expected 1 at %0d",
                               obs_pulses, obs_pulse_c, exp_pulse_c);
    end
    tests_run++;
    if (obs_done_c != exp_done_c || obs_pass !== 1'b1 || obs_fail !== 1'b0
        || obs_result !== 32'd0 || obs_timeout !== 1'b0 || obs_load_at_done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL jtag_result: got done@%0d p%b f%b t%b res %h expected done@%0d p1 f0 t0 res 0",
                               obs_done_c, obs_pass, obs_fail, obs_timeout, obs_result, exp_done_c);
    end
    tests_run++;
    if (obs_cnt !== 32'(exp_cnt)) begin
      tests_failed++; $display("[TB] FAIL jtag_cycle_cnt: got %0d expected %0d", obs_cnt, exp_cnt);
    end
  endtask

  task automatic test_flash_boot();
    model_run(1'b1, 0, 1'b1, 7, 32'd0, 32'd5);
    drive_run(1'b1, 1'b1, 32'd0, 0, 1'b1, 7, 32'd5, 1'b1, 500);
    tests_run++;
    if (obs_load_cycles != 0 || obs_pulses != 0) begin
      tests_failed++; $display("[TB] FAIL flash_no_load: got load %0d pulses %0d expected 0 0",
                               obs_load_cycles, obs_pulses);
    end
    tests_run++;
    if (obs_boot0 !== 1'b1 || obs_flash0 !== 1'b1 || obs_boot_end !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL flash_straps: got boot %b xip %b boot_end %b expected 1 1 1",
                               obs_boot0, obs_flash0, obs_boot_end);
    end
    tests_run++;
    if (obs_done_c != exp_done_c || obs_fail !== 1'b1 || obs_pass !== 1'b0 || obs_result !== 32'd5) begin
      tests_failed++; $display("[TB] FAIL flash_result: got done@%0d f%b p%b res %0d expected done@%0d f1 p0 res 5",
                               obs_done_c, obs_fail, obs_pass, obs_result, exp_done_c);
    end
    tests_run++;
    if (obs_cleared !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL flash_flags_cleared: got %b expected 1", obs_cleared);
    end
  endtask

  task automatic test_timeout();
    model_run(1'b1, 0, 1'b0, 0, 32'd10, 32'd0);
    drive_run(1'b1, 1'b0, 32'd10, 0, 1'b0, 0, 32'd0, 1'b1, 500);
    tests_run++;
    if (obs_done_c != exp_done_c || obs_timeout !== 1'b1 || obs_pass !== 1'b0 || obs_fail !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_flags: got done@%0d t%b p%b f%b expected done@%0d t1 p0 f0",
                               obs_done_c, obs_timeout, obs_pass, obs_fail, exp_done_c);
    end
    tests_run++;
    if (obs_cnt !== 32'd10) begin
      tests_failed++; $display("[TB] FAIL timeout_cycle_cnt: got %0d expected 10", obs_cnt);
    end
  endtask

  task automatic test_exit_vs_limit();
    for (int k = 10; k <= 11; k++) begin
      model_run(1'b1, 0, 1'b1, k, 32'd10, 32'd7);
      drive_run(1'b1, 1'b0, 32'd10, 0, 1'b1, k, 32'd7, 1'b0, 500);
      tests_run++;
      if (obs_done_c != exp_done_c || obs_timeout !== exp_timeout || obs_fail !== exp_fail
          || obs_cnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("[TB] FAIL exit_vs_limit_k%0d: got done@%0d t%b f%b cnt %0d expected done@%0d t%b f%b cnt %0d",
                                 k, obs_done_c, obs_timeout, obs_fail, obs_cnt,
                                 exp_done_c, exp_timeout, exp_fail, exp_cnt);
      end
    end
  endtask

  task automatic test_mid_run_reset();
    @(negedge clk);
    start_i = 1'b1; boot_sel_i = 1'b1; exec_flash_i = 1'b1; max_cycles_i = 32'd0;
    repeat (2 * RWC + 6) @(negedge clk);
    tests_run++;
    if (cycle_cnt_o !== 32'd5) begin
      tests_failed++; $display("[TB] FAIL start_ignored_in_run: got cnt %0d expected 5", cycle_cnt_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (soc_rst_no !== 1'b0 || cycle_cnt_o !== 32'd0 || boot_select_o !== 1'b0
        || {done_o, pass_o, fail_o, timeout_o} !== 4'b0) begin
      tests_failed++; $display("[TB] FAIL midrun_reset: got soc %b cnt %0d boot %b expected 0 0 0",
                               soc_rst_no, cycle_cnt_o, boot_select_o);
    end
    @(negedge clk); start_i = 1'b0; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (soc_rst_no !== 1'b1 || load_req_o !== 1'b0 || cycle_cnt_o !== 32'd0 || done_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midrun_idle_wait: got soc %b req %b cnt %0d done %b expected 1 0 0 0",
                               soc_rst_no, load_req_o, cycle_cnt_o, done_o);
    end
    model_run(1'b0, 2, 1'b1, 3, 32'd0, 32'd0);
    drive_run(1'b0, 1'b0, 32'd0, 2, 1'b1, 3, 32'd0, 1'b0, 500);
    tests_run++;
    if (obs_soc_low != RWC || obs_load_rise != exp_load_rise || obs_pulse_c != exp_pulse_c
        || obs_done_c != exp_done_c || obs_pass !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rerun_sequence: got low %0d rise %0d pulse %0d done %0d pass %b expected %0d %0d %0d %0d 1",
                               obs_soc_low, obs_load_rise, obs_pulse_c, obs_done_c, obs_pass,
                               RWC, exp_load_rise, exp_pulse_c, exp_done_c);
    end
  endtask

  task automatic test_load_timeout();
`ifdef TB_RUN_CTRL_LOAD_TIMEOUT_EN
    model_run(1'b0, -1, 1'b0, 0, 32'd0, 32'd0);
    drive_run(1'b0, 1'b0, 32'd0, -1, 1'b0, 0, 32'd0, 1'b1, 500);
    tests_run++;
    if (obs_load_cycles != exp_load_cycles || obs_done_c != exp_done_c || obs_timeout !== 1'b1
        || obs_load_at_done !== 1'b0 || obs_pulses != 0) begin
      tests_failed++; $display("[TB] FAIL load_timeout: got load %0d done@%0d t%b req %b expected %0d done@%0d t1 req 0",
                               obs_load_cycles, obs_done_c, obs_timeout, obs_load_at_done,
                               exp_load_cycles, exp_done_c);
    end
`else
    @(negedge clk);
    start_i = 1'b1; boot_sel_i = 1'b0; max_cycles_i = 32'd3;
    @(negedge clk); start_i = 1'b0;
    repeat (2 * RWC + 1000) begin
      @(negedge clk);
      exit_valid_i = 1'($urandom_range(0, 1));
    end
    exit_valid_i = 1'b0;
    tests_run++;
    if (load_req_o !== 1'b1 || done_o !== 1'b0 || set_exit_loop_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL load_waits_forever: got req %b done %b exit_loop %b expected 1 0 0",
                               load_req_o, done_o, set_exit_loop_o);
    end
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif
  endtask

  task automatic test_random();
    bit boot, flash, use_exit;
    int d, k;
    logic [31:0] maxc, val;
    for (int i = 0; i < 25; i++) begin
      boot     = 1'($urandom_range(0, 1));
      flash    = 1'($urandom_range(0, 1));
      d        = int'($urandom_range(0, 6));
      k        = int'($urandom_range(0, 30));
      maxc     = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      use_exit = (maxc == 32'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      val      = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      model_run(boot, d, use_exit, k, maxc, val);
      drive_run(boot, flash, maxc, d, use_exit, k, val, 1'b1, 1000);
      tests_run++;
      if (obs_done_c != exp_done_c || obs_timeout !== exp_timeout || obs_pass !== exp_pass
          || obs_fail !== exp_fail || obs_result !== exp_result || obs_cnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("[TB] FAIL random_%0d_result: got done@%0d t%b p%b f%b res %h cnt %0d expected done@%0d t%b p%b f%b res %h cnt %0d",
                                 i, obs_done_c, obs_timeout, obs_pass, obs_fail, obs_result, obs_cnt,
                                 exp_done_c, exp_timeout, exp_pass, exp_fail, exp_result, exp_cnt);
      end
      tests_run++;
      if (obs_load_cycles != exp_load_cycles || obs_pulse_c != exp_pulse_c
          || obs_soc_low != RWC || obs_boot_end !== boot || obs_flash0 !== (boot & flash)) begin
        tests_failed++; $display("[TB] FAIL random_%0d_sequence: got load %0d pulse %0d low %0d boot %b xip %b expected %0d %0d %0d %b %b",
                                 i, obs_load_cycles, obs_pulse_c, obs_soc_low, obs_boot_end, obs_flash0,
                                 exp_load_cycles, exp_pulse_c, RWC, boot, boot & flash);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jtag_boot();
    test_flash_boot();
    test_timeout();
    test_exit_vs_limit();
    test_mid_run_reset();
    test_load_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "[TB] aborted");
  end

endmodule
